// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART register interface.
//   - Register addresses on the 2-bit request bus (DATA, STATUS, CTRL, SCRATCH).
//   - Bit positions of the STATUS and CTRL registers.
//   - Baud-rate select encoding driven to the baud generator.
//   - CTRL reset value and a helper that packs the CTRL read image.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_SCRATCH = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_RXOVF    = 5;
  localparam int ST_TXOVF    = 6;
  localparam int ST_CNT_LSB  = 8;
  localparam int ST_CNT_CLR  = 15;

  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_RX_EN    = 1;
  localparam int CTRL_BAUD_LSB = 2;
  localparam int CTRL_IRQ_RX   = 4;
  localparam int CTRL_IRQ_TX   = 5;
  localparam int CTRL_IRQ_ERR  = 6;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'd0,
    BAUD_19200  = 2'd1,
    BAUD_57600  = 2'd2,
    BAUD_115200 = 2'd3
  } baud_sel_e;

  localparam logic [15:0] CTRL_RST = 16'h0003;

  // Builds the 16-bit CTRL read image; unimplemented bits read 0.
  function automatic logic [15:0] ctrl_pack(logic tx_en, logic rx_en,
                                            baud_sel_e baud, logic [2:0] irq_en);
    logic [15:0] v;
    v = '0;
    v[CTRL_TX_EN]               = tx_en;
    v[CTRL_RX_EN]               = rx_en;
    v[CTRL_BAUD_LSB +: 2]       = baud;
    v[CTRL_IRQ_RX]              = irq_en[0];
    v[CTRL_IRQ_TX]              = irq_en[1];
    v[CTRL_IRQ_ERR]             = irq_en[2];
    return v;
  endfunction

endpackage

// File: rtl/uart_csr_if.sv
// uart_csr_if: 16-bit register request bus for the UART CSR block.
//   req_i   : one transfer per cycle, never stalled
//   we_i    : 1 = write, 0 = read
//   addr_i  : 2-bit register address
//   wdata_i : write data
//   rdata_o : registered read data (valid one cycle after a read request)
//   rvalid_o: read data valid pulse
// Signal suffixes are from the CSR block's point of view (slave modport).
interface uart_csr_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  addr_i;
  logic [15:0] wdata_i;
  logic [15:0] rdata_o;
  logic        rvalid_o;

  modport master (output req_i, we_i, addr_i, wdata_i,
                  input  rdata_o, rvalid_o);
  modport slave  (input  req_i, we_i, addr_i, wdata_i,
                  output rdata_o, rvalid_o);
endinterface

// File: rtl/uart_sat_cnt.sv
// uart_sat_cnt: saturating up-counter with synchronous clear.
//   clk_i, rst_i : clock, synchronous active-high reset
//   inc_i        : increment request (ignored once the counter is at all-ones)
//   clr_i        : clear request; clear together with increment yields 1
//   cnt_o        : current count
module uart_sat_cnt #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      // The event coinciding with the clear is still counted.
      cnt_d = inc_i ? Width'(1) : '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_csr.sv
// uart_csr: UART register-interface controller.
// Decodes the request bus into TX FIFO pushes, RX FIFO pops, control
// configuration and status/error reporting.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   bus                   : request bus (uart_csr_if.slave)
//   tx_wr_en_o/_data_o    : TX FIFO push (combinational, request cycle)
//   tx_full_i, tx_empty_i : TX FIFO flags;  tx_busy_i : transmitter busy
//   rx_rd_en_o            : RX FIFO pop (combinational, request cycle)
//   rx_rd_data_i          : RX FIFO head (first-word fall-through)
//   rx_full_i, rx_empty_i : RX FIFO flags;  rx_push_i : receiver write strobe
//   tx_en_o, rx_en_o      : enables;  baud_sel_o : baud select
//   irq_o                 : registered level interrupt
// Build option: define UART_CSR_IRQ_EN to implement the interrupt enables
// CTRL[6:4] and irq_o; otherwise those bits read 0 and irq_o is tied low.
module uart_csr
  import uart_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int CntWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  uart_csr_if.slave            bus,
  output logic                 tx_wr_en_o,
  output logic [DataWidth-1:0] tx_wr_data_o,
  input  logic                 tx_full_i,
  input  logic                 tx_empty_i,
  input  logic                 tx_busy_i,
  output logic                 rx_rd_en_o,
  input  logic [DataWidth-1:0] rx_rd_data_i,
  input  logic                 rx_full_i,
  input  logic                 rx_empty_i,
  input  logic                 rx_push_i,
  output logic                 tx_en_o,
  output logic                 rx_en_o,
  output logic [1:0]           baud_sel_o,
  output logic                 irq_o
);

  logic          tx_en_q, tx_en_d, rx_en_q, rx_en_d;
  baud_sel_e     baud_q, baud_d;
  logic          txovf_q, txovf_d, rxovf_q, rxovf_d;
  logic [15:0]   scratch_q, scratch_d, rdata_q, rdata_d;
  logic          rvalid_q;
  logic [2:0]    irq_en;
  logic [CntWidth-1:0] ovr_cnt;
  logic          rd_req, wr_req, data_wr, st_wr, ctrl_wr, txovf_set, ovr_evt;
  logic [15:0]   wd, status, rd_val;

  assign wd = bus.wdata_i;

  // Reset masks the request so no strobe or response leaves the reset cycle.
  assign rd_req  = bus.req_i & ~bus.we_i & ~rst_i;
  assign wr_req  = bus.req_i &  bus.we_i & ~rst_i;
  assign data_wr = wr_req & (bus.addr_i == ADDR_DATA);
  assign st_wr   = wr_req & (bus.addr_i == ADDR_STATUS);
  assign ctrl_wr = wr_req & (bus.addr_i == ADDR_CTRL);

  assign tx_wr_en_o   = data_wr & tx_en_q & ~tx_full_i;
  assign tx_wr_data_o = tx_wr_en_o ? wd[DataWidth-1:0] : '0;
  assign rx_rd_en_o   = rd_req & (bus.addr_i == ADDR_DATA) & ~rx_empty_i;

  // A push into a full RX FIFO is lost unless a pop frees a slot this cycle.
  assign txovf_set = data_wr & tx_en_q & tx_full_i;
  assign ovr_evt   = rx_push_i & rx_full_i & ~rx_rd_en_o;

  uart_sat_cnt #(.Width(CntWidth)) u_ovr_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ovr_evt),
    .clr_i (st_wr & wd[ST_CNT_CLR]),
    .cnt_o (ovr_cnt)
  );

  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = tx_full_i;
    status[ST_TX_EMPTY] = tx_empty_i;
    status[ST_RX_FULL]  = rx_full_i;
    status[ST_RX_EMPTY] = rx_empty_i;
    status[ST_TX_BUSY]  = tx_busy_i;
    status[ST_RXOVF]    = rxovf_q;
    status[ST_TXOVF]    = txovf_q;
    status[ST_CNT_LSB +: 8] = 8'(ovr_cnt);

    case (bus.addr_i)
      ADDR_DATA:    rd_val = rx_empty_i ? '0 : 16'(rx_rd_data_i);
      ADDR_STATUS:  rd_val = status;
      ADDR_CTRL:    rd_val = ctrl_pack(tx_en_q, rx_en_q, baud_q, irq_en);
      ADDR_SCRATCH: rd_val = scratch_q;
      default:      rd_val = '0;
    endcase

    // Sticky flags: a set in the same cycle as a clear wins.
    txovf_d = txovf_set | (txovf_q & ~(st_wr & wd[ST_TXOVF]));
    rxovf_d = ovr_evt   | (rxovf_q & ~(st_wr & wd[ST_RXOVF]));

    tx_en_d   = ctrl_wr ? wd[CTRL_TX_EN] : tx_en_q;
    rx_en_d   = ctrl_wr ? wd[CTRL_RX_EN] : rx_en_q;
    baud_d    = ctrl_wr ? baud_sel_e'(wd[CTRL_BAUD_LSB +: 2]) : baud_q;
    scratch_d = (wr_req && bus.addr_i == ADDR_SCRATCH) ? wd : scratch_q;
    rdata_d   = rd_req ? rd_val : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_en_q   <= CTRL_RST[CTRL_TX_EN];
      rx_en_q   <= CTRL_RST[CTRL_RX_EN];
      baud_q    <= baud_sel_e'(CTRL_RST[CTRL_BAUD_LSB +: 2]);
      txovf_q   <= 1'b0;
      rxovf_q   <= 1'b0;
      scratch_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      tx_en_q   <= tx_en_d;
      rx_en_q   <= rx_en_d;
      baud_q    <= baud_d;
      txovf_q   <= txovf_d;
      rxovf_q   <= rxovf_d;
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rd_req;
    end
  end

`ifdef UART_CSR_IRQ_EN
  logic [2:0] irq_en_q, irq_en_d;
  logic       irq_q, irq_d;

  always_comb begin
    irq_en_d = ctrl_wr ? {wd[CTRL_IRQ_ERR], wd[CTRL_IRQ_TX], wd[CTRL_IRQ_RX]} : irq_en_q;
    irq_d    = (irq_en_q[0] & ~rx_empty_i)
             | (irq_en_q[1] &  tx_empty_i)
             | (irq_en_q[2] & (rxovf_q | txovf_q));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_en_q <= {CTRL_RST[CTRL_IRQ_ERR], CTRL_RST[CTRL_IRQ_TX], CTRL_RST[CTRL_IRQ_RX]};
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en = irq_en_q;
  assign irq_o  = irq_q;
`else
  assign irq_en = 3'b000;
  assign irq_o  = 1'b0;
`endif

  assign bus.rdata_o  = rdata_q;
  assign bus.rvalid_o = rvalid_q;
  assign tx_en_o      = tx_en_q;
  assign rx_en_o      = rx_en_q;
  assign baud_sel_o   = baud_q;

endmodule

// File: doc/uart_csr.md
# uart_csr

Register-interface controller for the UART. Decodes a 2-bit-addressed 16-bit request bus into TX FIFO pushes, RX FIFO pops, control configuration (enables, baud select) and status/error reporting. Sits between the system bus and the UART FIFOs, baud generator and transmitter, and owns all software-visible UART state.

## Interface
- `DataWidth`, 8: UART character width; must be ≤ 16.
- `CntWidth`, 8: width of the saturating RX-overrun counter; must be ≤ 8.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `req_i` in 1: bus request; one transfer per cycle; never stalled.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 2: register address.
- `wdata_i` in 16: write data.
- `rdata_o` out 16: read data, registered.
- `rvalid_o` out 1: read data valid, one-cycle pulse.
- `tx_wr_en_o` out 1: TX FIFO push strobe.
- `tx_wr_data_o` out DataWidth: TX FIFO push data.
- `tx_full_i`, `tx_empty_i` in 1: TX FIFO flags.
- `tx_busy_i` in 1: transmitter busy.
- `rx_rd_en_o` out 1: RX FIFO pop strobe.
- `rx_rd_data_i` in DataWidth: RX FIFO head (first-word fall-through, valid when `rx_empty_i`=0).
- `rx_full_i`, `rx_empty_i` in 1: RX FIFO flags.
- `rx_push_i` in 1: receiver write strobe into the RX FIFO.
- `tx_en_o`, `rx_en_o` out 1: transmitter/receiver enables.
- `baud_sel_o` out 2: baud-rate select to the baud generator.
- `irq_o` out 1: level interrupt, registered.

## Operation
- Address 0 DATA. Write: if `tx_en_o`=1 and `tx_full_i`=0, pulse `tx_wr_en_o` with `wdata_i[DataWidth-1:0]`. If full, drop the byte and set sticky TXOVF. If tx disabled, drop silently. Read: if `rx_empty_i`=0, return zero-extended `rx_rd_data_i` and pulse `rx_rd_en_o`. If empty, return 0 with no pop.
- Address 1 STATUS. Read bits: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy, [5] RXOVF, [6] TXOVF, [15:8] overrun count (zero-extended). Write: bits 5 and 6 are write-1-to-clear; bit 15 = 1 clears the count.
- Address 2 CTRL (RW): [0] tx_en, [1] rx_en, [3:2] baud_sel, [4] irq_rx_en, [5] irq_tx_en, [6] irq_err_en. Other bits read 0. Reset value 0x0003.
- Address 3 SCRATCH: 16-bit RW, reset value 0.
- Overrun event = `rx_push_i` & `rx_full_i` & ~`rx_rd_en_o`. It sets RXOVF and increments the counter, which saturates at 2^CntWidth−1.
- Set and clear of a sticky bit in the same cycle: set wins. Increment and clear of the count in the same cycle: count becomes 1.
- `irq_o` is registered from: (irq_rx_en & ~rx_empty) | (irq_tx_en & tx_empty) | (irq_err_en & (RXOVF|TXOVF)).

## Timing
- Reset values: `rdata_o`=0, `rvalid_o`=0, `tx_wr_en_o`=0, `tx_wr_data_o`=0, `rx_rd_en_o`=0, `tx_en_o`=1, `rx_en_o`=1, `baud_sel_o`=0, `irq_o`=0. Sticky bits, count and scratch are 0.
- `tx_wr_en_o` and `rx_rd_en_o` are combinational, in the request cycle. `tx_full_i` and `rx_empty_i` are sampled in that same cycle.
- Read latency is 1 cycle: `rdata_o`/`rvalid_o` are valid the cycle after `req_i`&~`we_i`. `rdata_o` holds its value until the next read.
- Writes produce no response. Register writes take effect on the next edge, and the STATUS seen by a read reflects flops before that edge.
- Back-to-back reads of DATA pop one entry per cycle.
- `irq_o` lags its sources by 1 cycle.
- Reset asserted mid-transfer: the pending read response is suppressed, all state returns to reset values at the edge, and no strobe is issued in the reset cycle.

## Configuration
- `UART_CSR_IRQ_EN` defined: interrupt logic, CTRL[6:4] and `irq_o` are as above.
- `UART_CSR_IRQ_EN` undefined: CTRL[6:4] are not stored and read 0, and `irq_o` is tied to 0.

## Structure
- `uart_pkg` holds:
  - address constants ADDR_DATA, ADDR_STATUS, ADDR_CTRL, ADDR_SCRATCH;
  - STATUS/CTRL bit-index localparams;
  - a `baud_sel_e` enum (2-bit);
  - the CTRL reset constant.
- Sub-module `uart_sat_cnt`: saturating counter with inc/clr inputs and parameter width, used for the overrun count.

## Test plan
- Reset, then read CTRL → `rvalid_o` one cycle later, `rdata_o`=0x0003. Read STATUS → 0x000A (both FIFOs empty).
- Write DATA 0x0041 with tx not full → `tx_wr_en_o`=1, `tx_wr_data_o`=0x41 in the same cycle. Repeat with `tx_full_i`=1 → no strobe, STATUS bit 6=1. Write STATUS 0x0040 → bit 6 clears.
- Put 0x5A at the RX head and read DATA twice back-to-back, the second read with `rx_empty_i`=1 → first returns 0x005A with one `rx_rd_en_o` pulse, second returns 0x0000 with no pop.
- Hold `rx_full_i`=1 and pulse `rx_push_i` 300 times with no reads → count reads 0xFF (saturated) and RXOVF=1. Pulse `rx_push_i` together with a DATA read → no increment. Write STATUS 0x8020 in the same cycle as an overrun → RXOVF stays 1, count=1.
- With `UART_CSR_IRQ_EN` defined, write CTRL 0x0013 and drive `rx_empty_i` 1→0 → `irq_o` rises one cycle later. Build without the macro → `irq_o`=0 and CTRL reads 0x0003.
